// File: rtl/saratoga_pkg.sv
// Shared types and defaults for the saratoga core and its bus bridges.
package saratoga_pkg;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_EXOKAY = 2'b01,
    AXIL_SLVERR = 2'b10,
    AXIL_DECERR = 2'b11
  } axil_resp_t;

  // Anything other than OKAY is reported to the core as a fault; the core
  // never issues exclusive accesses, so EXOKAY is unexpected as well.
  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != AXIL_OKAY;
  endfunction

endpackage

// File: rtl/dbus_axil_bridge.sv
// Bridges the core's DBus AXI-window port to a single AXI4-Lite manager.
// One core access becomes exactly one AXI-Lite transaction; the core is
// stalled via axi_busy and gets read data / fault back in a one-cycle RESP.
module dbus_axil_bridge
  import saratoga_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axi_rd_en,
  input  logic                      axi_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strobe,
  output logic [31:0]               axi_rd_data,
  output logic                      axi_access_fault,
  output logic                      axi_busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [31:0]               m_wdata,
  output logic [3:0]                m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [31:0]               m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA, ST_RESP, ST_DRAIN
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                    state_reg;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]               wdata_reg;
  logic [3:0]                wstrb_reg;
  logic                      awvalid_reg, wvalid_reg, arvalid_reg;
  logic                      bready_reg, rready_reg;
  logic                      resp_pending_reg;  // B or R still owed by the slave
  logic                      drain_reg;         // timed out, must drain after RESP
  logic [31:0]               rd_data_reg;
  logic                      fault_reg;
  logic [CNT_W-1:0]          count_reg;

  logic aw_left, w_left, ar_left, resp_left;
  logic b_hs, r_hs, timeout_hit, active;

  // Per-channel status after this cycle's handshakes.
  assign aw_left   = awvalid_reg & ~m_awready;
  assign w_left    = wvalid_reg & ~m_wready;
  assign ar_left   = arvalid_reg & ~m_arready;
  assign b_hs      = bready_reg & m_bvalid;
  assign r_hs      = rready_reg & m_rvalid;
  assign resp_left = resp_pending_reg & ~b_hs & ~r_hs;
  assign active    = state_reg inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};

  // count_reg holds the number of earlier wait cycles, so the current cycle is
  // the TIMEOUT_CYCLES-th one when count_reg + 1 reaches the limit.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = ({1'b0, count_reg} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT_CYCLES);
    end
  endgenerate

  // Stall is combinational so the core freezes in the very cycle it asks.
  assign axi_busy = ((state_reg == ST_IDLE) & (axi_rd_en | axi_wr_en)) |
                    active | (state_reg == ST_DRAIN);

  assign m_awaddr         = addr_reg;
  assign m_araddr         = addr_reg;
  assign m_awprot         = 3'b000;
  assign m_arprot         = 3'b000;
  assign m_wdata          = wdata_reg;
  assign m_wstrb          = wstrb_reg;
  assign m_awvalid        = awvalid_reg;
  assign m_wvalid         = wvalid_reg;
  assign m_arvalid        = arvalid_reg;
  assign m_bready         = bready_reg;
  assign m_rready         = rready_reg;
  assign axi_rd_data      = rd_data_reg;
  assign axi_access_fault = fault_reg;

  // Bridge FSM with registered bus outputs, response registers and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      wstrb_reg        <= '0;
      awvalid_reg      <= 1'b0;
      wvalid_reg       <= 1'b0;
      arvalid_reg      <= 1'b0;
      bready_reg       <= 1'b0;
      rready_reg       <= 1'b0;
      resp_pending_reg <= 1'b0;
      drain_reg        <= 1'b0;
      rd_data_reg      <= '0;
      fault_reg        <= 1'b0;
      count_reg        <= '0;
    end else begin
      // Valids drop independently on their own handshake, in every state.
      awvalid_reg <= aw_left;
      wvalid_reg  <= w_left;
      arvalid_reg <= ar_left;
      if (b_hs | r_hs) resp_pending_reg <= 1'b0;
      rd_data_reg <= '0;
      fault_reg   <= 1'b0;
      if (active) count_reg <= count_reg + CNT_W'(1);

      case (state_reg)
        ST_IDLE: begin
          if (axi_rd_en & axi_wr_en) begin
            state_reg <= ST_RESP;
            fault_reg <= 1'b1;
          end else if (axi_wr_en | axi_rd_en) begin
            addr_reg         <= axi_addr;
            wdata_reg        <= wr_data;
            wstrb_reg        <= wr_strobe;
            resp_pending_reg <= 1'b1;
            count_reg        <= '0;
            if (axi_wr_en) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= ST_WR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          if (timeout_hit) begin
            state_reg  <= ST_RESP;
            fault_reg  <= 1'b1;
            drain_reg  <= 1'b1;
            bready_reg <= 1'b1;
          end else if (!aw_left && !w_left) begin
            state_reg  <= ST_WR_RESP;
            bready_reg <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (b_hs) begin
            state_reg  <= ST_RESP;
            bready_reg <= 1'b0;
            fault_reg  <= resp_is_fault(m_bresp);
          end else if (timeout_hit) begin
            state_reg <= ST_RESP;
            fault_reg <= 1'b1;
            drain_reg <= 1'b1;
          end
        end
        ST_RD_ADDR: begin
          if (timeout_hit) begin
            state_reg  <= ST_RESP;
            fault_reg  <= 1'b1;
            drain_reg  <= 1'b1;
            rready_reg <= 1'b1;
          end else if (!ar_left) begin
            state_reg  <= ST_RD_DATA;
            rready_reg <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            state_reg  <= ST_RESP;
            rready_reg <= 1'b0;
            if (resp_is_fault(m_rresp)) fault_reg <= 1'b1;
            else rd_data_reg <= m_rdata;
          end else if (timeout_hit) begin
            state_reg <= ST_RESP;
            fault_reg <= 1'b1;
            drain_reg <= 1'b1;
          end
        end
        ST_RESP: begin
          state_reg <= drain_reg ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (!aw_left && !w_left && !ar_left && !resp_left) begin
            state_reg  <= ST_IDLE;
            bready_reg <= 1'b0;
            rready_reg <= 1'b0;
            drain_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
